fifo_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit synchronous FIFO: drains bytes from it and serialises them as 8N1 (or 8N2) UART frames on a single TX line.
- Handles the FIFO's one-cycle read latency: data is valid on the clock edge after the read enable.
- Sits between the FIFO read port and the board-level TX pin, for DMM measurement/debug streaming.

---
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the synchronous FIFO and serialises them as 8N1/8N2
// UART frames; the TX pin is registered and aligned with the frame state.
module fifo_uart_tx #(
   parameter int pClksPerBit = 104,
   parameter int pStopBits   = 1
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEnable,
   input  logic       iFifoEmpty,
   output logic       oFifoRdEn,
   input  logic [7:0] iFifoData,
   output logic       oTx,
   output logic       oBusy,
   output logic       oByteDone
);

   localparam int CW = $clog2(pClksPerBit);
   localparam logic [CW-1:0] BAUD_LAST = CW'(pClksPerBit - 1);
   localparam logic [2:0]    STOP_LAST = 3'(pStopBits - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic baud_end;
   logic stop_end;
   logic start_ok;

   assign baud_end = (cnt_q == BAUD_LAST);
   assign stop_end = baud_end && (bit_q == STOP_LAST);
   assign start_ok = iEnable && !iFifoEmpty;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_ok) state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT:  state_d = S_START;
         S_START: if (baud_end) state_d = S_DATA;
         S_DATA:  if (baud_end && bit_q == 3'd7) state_d = S_STOP;
         S_STOP: begin
            if (stop_end) state_d = start_ok ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = shift_q;
      unique case (state_q)
         S_WAIT: shift_d = iFifoData;
         S_START: begin
            cnt_d = baud_end ? '0 : cnt_q + 1'b1;
         end
         S_DATA: begin
            cnt_d = baud_end ? '0 : cnt_q + 1'b1;
            bit_d = bit_q;
            if (baud_end) begin
               bit_d   = (bit_q == 3'd7) ? 3'd0 : bit_q + 3'd1;
               shift_d = shift_q >> 1;
            end
         end
         S_STOP: begin
            cnt_d = baud_end ? '0 : cnt_q + 1'b1;
            bit_d = bit_q;
            if (baud_end) bit_d = stop_end ? 3'd0 : bit_q + 3'd1;
         end
         default: ;
      endcase
      // Pin level is computed from the next state so it lines up with it
      unique case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      oFifoRdEn = (state_q == S_FETCH);
      oBusy     = (state_q != S_IDLE);
      oByteDone = (state_q == S_STOP) && stop_end;
      oTx       = tx_q;
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Random and directed bench for fifo_uart_tx: two instances (one and two
// stop bits) checked every cycle against a queued expected-waveform model.
module tb_fifo_uart_tx;

   localparam int P = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en;
   logic       empty [2];
   logic [7:0] fdata [2];
   logic       rd    [2];
   logic       tx    [2];
   logic       busy  [2];
   logic       done  [2];

   fifo_uart_tx #(.pClksPerBit(P), .pStopBits(1)) u_dut0 (
      .iClk(clk), .iRst(rst), .iEnable(en),
      .iFifoEmpty(empty[0]), .oFifoRdEn(rd[0]),
      .iFifoData(fdata[0]), .oTx(tx[0]),
      .oBusy(busy[0]), .oByteDone(done[0])
   );

   fifo_uart_tx #(.pClksPerBit(P), .pStopBits(2)) u_dut1 (
      .iClk(clk), .iRst(rst), .iEnable(en),
      .iFifoEmpty(empty[1]), .oFifoRdEn(rd[1]),
      .iFifoData(fdata[1]), .oTx(tx[1]),
      .oBusy(busy[1]), .oByteDone(done[1])
   );

   logic [7:0] fq  [2][$];
   logic [3:0] exq [2][$];
   int checks = 0;
   int errors = 0;
   int pushed = 0;
   int cyc    = 0;
   int pulses [2] = '{0, 0};
   int gap    [2] = '{0, 0};
   int hrun   [2] = '{0, 0};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Expected {tx, rdEn, busy, byteDone} for every cycle of one frame
   function automatic void frame(input int d, input logic [7:0] b);
      int s;
      s = d + 1;
      exq[d].push_back(4'b1110);
      exq[d].push_back(4'b1010);
      for (int i = 0; i < P; i++) exq[d].push_back(4'b0010);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < P; i++) exq[d].push_back({b[k], 3'b010});
      for (int i = 0; i < s * P; i++)
         exq[d].push_back({3'b101, (i == s * P - 1)});
   endfunction

   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         logic [3:0] e;
         e = (exq[d].size() > 0) ? exq[d][0] : 4'b1000;
         chk($sformatf("cyc%0d dut%0d {tx,rd,busy,done}", cyc, d),
             {28'd0, tx[d], rd[d], busy[d], done[d]}, {28'd0, e});
         if (exq[d].size() > 0) void'(exq[d].pop_front());
         if (rd[d] === 1'b1) begin
            pulses[d]++;
            if (fq[d].size() > 0) fdata[d] = fq[d].pop_front();
         end
         if (tx[d] === 1'b1) hrun[d]++;
         else begin
            if (hrun[d] > 0) gap[d] = hrun[d];
            hrun[d] = 0;
         end
         if (rst) exq[d].delete();
         else if (exq[d].size() == 0 && en && fq[d].size() > 0)
            frame(d, fq[d][0]);
         empty[d] = (fq[d].size() == 0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      fq[0].push_back(b);
      fq[1].push_back(b);
      pushed++;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 5000; k++) begin
         if (fq[0].size() == 0 && fq[1].size() == 0 &&
             exq[0].size() == 0 && exq[1].size() == 0 &&
             !busy[0] && !busy[1]) break;
         step(1);
      end
      if (k == 5000) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_rd(input string nm);
      int k;
      for (k = 0; k < 500; k++) begin
         if (rd[0]) break;
         step(1);
      end
      if (k == 500) chk({nm, "_rd_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      logic [9:0] seq;
      int n;
      rst = 1'b1;
      en  = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("reset_tx", tx[0], 1);
      chk("reset_busy", busy[0], 0);
      chk("reset_rd", rd[0], 0);
      chk("reset_done", done[1], 0);

      // single byte, model pinned by literal values
      push(8'hA5);
      en = 1'b1;
      step(1);
      chk("model_len0", exq[0].size(), 42);
      chk("model_len1", exq[1].size(), 46);
      chk("model_first", exq[0][0], 4'b1110);
      chk("model_last0", exq[0][41], 4'b1011);
      chk("model_last1", exq[1][45], 4'b1011);
      for (int i = 0; i < 10; i++) seq[i] = exq[0][2 + 4 * i][3];
      chk("model_a5_bits", seq, 10'b1101001010);
      wait_idle("single");

      // back-to-back
      push(8'h00);
      push(8'hFF);
      wait_idle("b2b");
      chk("gap_stop1", gap[0], 6);
      chk("gap_stop2", gap[1], 10);

      // disabled with data present, then empty with enable
      en = 1'b0;
      push(8'h11);
      step(200);
      chk("disabled_reads", pulses[0], 3);
      en = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n++;
         if (tx[0] == 1'b0) break;
      end
      chk("start_latency", n, 4);
      wait_idle("latency");
      step(200);

      // reset during data bit 3
      push(8'h5A);
      push(8'h77);
      wait_rd("rst");
      step(19);
      rst = 1'b1;
      step(1);
      chk("abort_tx", tx[0], 1);
      chk("abort_busy", busy[0], 0);
      chk("abort_done", done[0], 0);
      rst = 1'b0;
      wait_idle("after_rst");

      // enable dropped at start bit with a second byte queued
      push(8'h3C);
      push(8'h99);
      wait_rd("pause");
      step(2);
      en = 1'b0;
      step(150);
      chk("paused_reads", pulses[0], 7);
      chk("paused_left", fq[0].size(), 1);
      en = 1'b1;
      wait_idle("resume");

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0 && fq[0].size() < 6)
            push(8'($urandom));
         if ($urandom_range(0, 99) == 0) en = ~en;
         rst = ($urandom_range(0, 1999) == 0);
         step(1);
      end
      rst = 1'b0;
      en  = 1'b1;
      wait_idle("random");
      chk("reads_dut0", pulses[0], pushed);
      chk("reads_dut1", pulses[1], pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
